ir_prefetch: RTL and testbench
==============================

# ir_prefetch

Parametrised instruction register with an integrated prefetch queue. It is the successor to the single-stage instruction register in the PDUA datapath. Instruction words arrive on busC and are buffered in a DEPTH-entry FIFO. The control unit pops the head into the architectural IR on demand. The IR is split into opcode and operand fields, with a synchronous clear that flushes both queue and IR.

## Interface
- DATA_WIDTH, 8, instruction word width (≥ OPCODE_WIDTH+1)
- OPCODE_WIDTH, 5, opcode field width; opcode = IR[DATA_WIDTH-1 -: OPCODE_WIDTH]
- DEPTH, 4, prefetch queue entries; power of two, ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is asynchronous and active-low (rst = 0 resets)
- sclr  input  1  synchronous flush of queue and IR
- wr_en  input  1  push busC into queue
- busC  input  DATA_WIDTH  instruction word from bus
- rd_en  input  1  load IR from queue head (ena of the old IR)
- opcode  output  OPCODE_WIDTH  IR upper field
- operand  output  DATA_WIDTH-OPCODE_WIDTH  IR lower field
- ir_valid  output  1  IR holds a word loaded by the last successful rd_en
- empty  output  1  queue count = 0
- full  output  1  queue count = DEPTH
- count  output  $clog2(DEPTH+1)  queue occupancy
- err  output  1  sticky overflow/underflow flag (see Configuration)

## Operation
- Storage: DEPTH×DATA_WIDTH array; write and read pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH; count is tracked separately.
- Priority per edge: rst > sclr > normal operation.
- sclr: pointers=0, count=0, IR=0, ir_valid=0. err is unchanged. wr_en/rd_en in the same cycle are ignored.
- Push, when !full: mem[wptr]<=busC, wptr++, count++.
- Push when full:
  - With rd_en: accepted; count unchanged.
  - Without rd_en: dropped; overflow.
- Pop, when !empty: IR<=mem[rptr], rptr++, count--, ir_valid<=1.
- Pop when empty:
  - With wr_en (bypass): IR<=busC, ir_valid<=1; queue unchanged.
  - Without wr_en: IR holds its value, ir_valid<=0; underflow.
- Simultaneous push and pop, non-empty: both performed; count unchanged; IR gets the old head.
- Outputs are combinational slices of the IR register. empty, full and count are derived from the registered count.

## Timing
- Reset values: IR=0, opcode=0, operand=0, ir_valid=0, empty=1, full=0, count=0, err=0; pointers=0.
- Push→pop latency:
  - A word pushed at edge N is poppable at edge N+1; it appears on opcode/operand after that edge.
  - Bypass: the word appears after the same edge it is pushed.
- Flags update on the same edge as the pointer change; no lookahead.
- rst deasserted mid-operation: queue contents are lost. Resumption requires new pushes.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- IR_ERR_FLAG_EN defined:
  - err is set on any dropped push (overflow) or empty pop without bypass (underflow).
  - err stays set until rst; sclr does not clear it.
- IR_ERR_FLAG_EN undefined: err tied to 0 and no error logic is built. Queue behaviour is identical in both builds.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then 1 → opcode=0, operand=0, empty=1, count=0, ir_valid=0, err=0.
- Fill and drain (defaults):
  - Push 0xA1,0xB2,0xC3,0xD4 → full=1, count=4.
  - A 5th push of 0xEE without rd_en → dropped, err=1 (macro on) / 0 (off).
  - 4 pops → opcode/operand = 0x14/1, 0x16/2, 0x18/3, 0x1A/4 in order; empty=1.
- Bypass: on an empty queue, wr_en=rd_en=1 with busC=0x5F → after one edge opcode=0x0B, operand=7, ir_valid=1, count=0.
- Underflow: empty queue, rd_en only → IR unchanged, ir_valid=0, err=1 (macro on).
- Wrap-around plus simultaneous push/pop:
  - Hold count=2 with continuous push+pop for 10 cycles, sequential data 0x01..0x0A.
  - IR sequence lags input by 2 words; count stays 2; no err.
- Flush: with count=3 and IR=0x77, assert sclr together with wr_en and rd_en → next cycle count=0, empty=1, IR=0, ir_valid=0, err unchanged.

Source files
------------

// File: rtl/ir_prefetch.sv
// Instruction register fed by a DEPTH-entry prefetch queue, with flush and bypass.
// Optional sticky overflow/underflow flag on err when IR_ERR_FLAG_EN is defined.
module ir_prefetch #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 5,
    parameter int DEPTH        = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sclr,
    input  logic                               wr_en,
    input  logic [DATA_WIDTH-1:0]              busC,
    input  logic                               rd_en,
    output logic [OPCODE_WIDTH-1:0]            opcode,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic                               ir_valid,
    output logic                               empty,
    output logic                               full,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic                               err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = DATA_WIDTH - OPCODE_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  vld_q, vld_d;

    logic empty_w, full_w;
    logic do_push, do_pop, bypass;

    assign empty_w = (cnt_q == '0);
    assign full_w  = (cnt_q == CW'(DEPTH));

    // An empty-queue read with a concurrent write takes busC straight into the IR.
    assign bypass  = !sclr && rd_en && wr_en && empty_w;
    assign do_pop  = !sclr && rd_en && !empty_w;
    assign do_push = !sclr && wr_en && !bypass && (!full_w || rd_en);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ir_d   = ir_q;
        vld_d  = vld_q;
        if (sclr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ir_d   = '0;
            vld_d  = 1'b0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
            if (do_pop) begin
                ir_d  = mem_q[rptr_q];
                vld_d = 1'b1;
            end else if (bypass) begin
                ir_d  = busC;
                vld_d = 1'b1;
            end else if (rd_en) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ir_q   <= '0;
            vld_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ir_q   <= ir_d;
            vld_q  <= vld_d;
        end
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= busC;
    end

`ifdef IR_ERR_FLAG_EN
    logic err_q;
    logic ovf, udf;

    assign ovf = !sclr && wr_en && full_w && !rd_en;
    assign udf = !sclr && rd_en && empty_w && !wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (ovf || udf) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign opcode   = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign operand  = ir_q[OW-1:0];
    assign ir_valid = vld_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = cnt_q;

endmodule

// File: tb/tb_ir_prefetch.sv
// Bench for ir_prefetch: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_ir_prefetch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclr = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] busC = '0;
    logic [4:0] opcode;
    logic [2:0] operand;
    logic       ir_valid, empty, full, err;
    logic [2:0] count;

    int tot = 0;
    int pass = 0;

`ifdef IR_ERR_FLAG_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    ir_prefetch #(.DATA_WIDTH(8), .OPCODE_WIDTH(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .sclr(sclr), .wr_en(wr_en), .busC(busC),
        .rd_en(rd_en), .opcode(opcode), .operand(operand),
        .ir_valid(ir_valid), .empty(empty), .full(full),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tot++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference model: a plain queue plus IR/valid/err state.
    logic [7:0] mq[$];
    logic [7:0] m_ir = '0;
    logic       m_vld = 1'b0;
    logic       m_err = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ir  = '0;
            m_vld = 1'b0;
            m_err = 1'b0;
        end else if (sclr) begin
            mq.delete();
            m_ir  = '0;
            m_vld = 1'b0;
        end else begin
            int n;
            n = mq.size();
            if (rd_en && n > 0) begin
                m_ir  = mq.pop_front();
                m_vld = 1'b1;
                if (wr_en) mq.push_back(busC);
            end else if (rd_en && wr_en) begin
                m_ir  = busC;
                m_vld = 1'b1;
            end else if (rd_en) begin
                m_vld = 1'b0;
                m_err = 1'b1;
            end else if (wr_en) begin
                if (n < 4) mq.push_back(busC);
                else m_err = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("m_opcode", opcode, m_ir[7:3]);
        chk("m_operand", operand, m_ir[2:0]);
        chk("m_valid", ir_valid, m_vld);
        chk("m_count", count, mq.size());
        chk("m_empty", empty, mq.size() == 0);
        chk("m_full", full, mq.size() == 4);
        chk("m_err", err, m_err & EXP_ERR);
    end

    task automatic cyc(input logic w, input logic r, input logic s,
                       input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        sclr  = s;
        busC  = d;
        @(posedge clk);
        #3;
        wr_en = 1'b0;
        rd_en = 1'b0;
        sclr  = 1'b0;
    endtask

    logic [7:0] fill_v [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [4:0] exp_op [4] = '{5'h14, 5'h16, 5'h18, 5'h1A};

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_err", err, 0);

        for (int i = 0; i < 4; i++) cyc(1, 0, 0, fill_v[i]);
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);

        cyc(1, 0, 0, 8'hEE);
        chk("ovf_count", count, 4);
        chk("ovf_err", err, EXP_ERR);

        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 8'h00);
            chk("drain_opcode", opcode, exp_op[i]);
            chk("drain_operand", operand, i + 1);
        end
        chk("drain_empty", empty, 1);

        cyc(1, 1, 0, 8'h5F);
        chk("byp_opcode", opcode, 5'h0B);
        chk("byp_operand", operand, 7);
        chk("byp_valid", ir_valid, 1);
        chk("byp_count", count, 0);

        cyc(0, 1, 0, 8'h00);
        chk("udf_opcode", opcode, 5'h0B);
        chk("udf_valid", ir_valid, 0);
        chk("udf_err", err, EXP_ERR);

        cyc(1, 0, 0, 8'h01);
        cyc(1, 0, 0, 8'h02);
        for (int k = 1; k <= 10; k++) begin
            logic [7:0] d;
            logic [7:0] e;
            d = 8'(k + 2);
            e = 8'(k);
            cyc(1, 1, 0, d);
            chk("wrap_ir", {opcode, operand}, e);
            chk("wrap_count", count, 2);
        end

        cyc(0, 0, 1, 8'h00);
        cyc(1, 0, 0, 8'h77);
        cyc(1, 1, 0, 8'h20);
        cyc(1, 0, 0, 8'h21);
        cyc(1, 0, 0, 8'h22);
        chk("pre_flush_count", count, 3);
        chk("pre_flush_ir", {opcode, operand}, 8'h77);
        cyc(1, 1, 1, 8'h99);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_ir", {opcode, operand}, 0);
        chk("flush_valid", ir_valid, 0);
        chk("flush_err", err, EXP_ERR);

        cyc(1, 0, 0, 8'h3C);
        cyc(0, 1, 0, 8'h00);
        chk("resume_opcode", opcode, 5'h07);
        chk("resume_operand", operand, 4);

        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'(8'h40 + i));
        cyc(1, 1, 0, 8'h55);
        chk("fullrw_count", count, 4);
        chk("fullrw_ir", {opcode, operand}, 8'h40);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00);
        chk("fullrw_last", {opcode, operand}, 8'h55);

        cyc(1, 0, 0, 8'h66);
        cyc(1, 0, 0, 8'h67);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_ir", {opcode, operand}, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 1, 0, 8'h00);
        chk("arst_lost", ir_valid, 0);
        repeat (2) @(posedge clk);
        #4;

        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule
